// File: rtl/gx4000_pkg.sv
// Shared GX4000 Plus ASIC unlock constants, used by the unlock sequencer and the ACID detector.
package gx4000_pkg;

   localparam int UNLOCK_LEN = 17;
   localparam int STATE_IDX  = 13;
   localparam int TIMER_W    = 16;

   localparam logic [7:0] ACID_PORT_HI = 8'hBC;

   localparam logic [7:0] UNLOCK_SEQ [0:16] = '{
      8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62, 8'h39, 8'h9C,
      8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE, 8'hFF, 8'hFF
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WRITE,
      ST_GAP,
      ST_CHECK
   } unlock_tx_state_t;

   typedef enum logic {
      MODE_UNLOCK,
      MODE_LOCK
   } unlock_mode_t;

   // Relock differs from unlock only in the STATE byte.
   function automatic logic [7:0] seq_byte(unlock_mode_t mode, logic [4:0] idx);
      logic [7:0] b;
      b = 8'h00;
      if (idx < 5'(UNLOCK_LEN))
         b = UNLOCK_SEQ[idx];
      if (mode == MODE_LOCK && idx == 5'(STATE_IDX))
         b = 8'h00;
      return b;
   endfunction

endpackage

// File: rtl/gx4000_cycle_timer.sv
// Loadable down-counter; zero is high once the loaded count has been exhausted.
module gx4000_cycle_timer
   import gx4000_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk_sys,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/gx4000_unlock_sequencer.sv
// Bus-master engine that writes the 17-byte Plus ASIC unlock/relock sequence to port &BCxx
// and confirms the outcome against the ACID detector.
//
// state    | meaning
// IDLE     | waiting for unlock_req / lock_req with plus_mode set
// REQ      | bus_req high, waiting for bus_ack (bounded by ACK_TIMEOUT)
// WRITE    | io_wr high for WR_CYCLES with the current sequence byte
// GAP      | io_wr low for GAP_CYCLES, address/data held
// CHECK    | bus released, settle CHECK_CYCLES then judge asic_valid
module gx4000_unlock_sequencer
   import gx4000_pkg::*;
#(
   parameter int WR_CYCLES    = 4,
   parameter int GAP_CYCLES   = 4,
   parameter int ACK_TIMEOUT  = 1023,
   parameter int CHECK_CYCLES = 2
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        plus_mode,
   input  logic        unlock_req,
   input  logic        lock_req,
   input  logic        asic_valid,
   output logic        bus_req,
   input  logic        bus_ack,
   output logic [15:0] io_addr,
   output logic [7:0]  io_data,
   output logic        io_wr,
   output logic        busy,
   output logic [4:0]  byte_idx,
   output logic        done,
   output logic        error
);

   localparam logic [TIMER_W-1:0] WR_LOAD    = TIMER_W'(WR_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] ACK_LOAD   = TIMER_W'(ACK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] CHECK_LOAD = TIMER_W'(CHECK_CYCLES - 1);
   localparam logic [4:0]         LAST_IDX   = 5'(UNLOCK_LEN - 1);

   unlock_tx_state_t     state, state_nx;
   unlock_mode_t         mode, mode_nx;
   logic [4:0]           byte_idx_nx;
   logic                 done_nx, error_nx;
   logic                 tmr_load, tmr_zero;
   logic [TIMER_W-1:0]   tmr_val;
   logic                 on_bus;

   gx4000_cycle_timer #(.W(TIMER_W)) u_timer (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         mode     <= MODE_UNLOCK;
         byte_idx <= '0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         state    <= state_nx;
         mode     <= mode_nx;
         byte_idx <= byte_idx_nx;
         done     <= done_nx;
         error    <= error_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      mode_nx     = mode;
      byte_idx_nx = byte_idx;
      done_nx     = 1'b0;
      error_nx    = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      unique case (state)
         ST_IDLE: begin
            if (plus_mode && (unlock_req || lock_req)) begin
               mode_nx     = unlock_req ? MODE_UNLOCK : MODE_LOCK;
               byte_idx_nx = '0;
               tmr_load    = 1'b1;
               tmr_val     = ACK_LOAD;
               state_nx    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_ack) begin
               tmr_load = 1'b1;
               tmr_val  = WR_LOAD;
               state_nx = ST_WRITE;
            end else if (tmr_zero) begin
               error_nx = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (!bus_ack || !plus_mode) begin
               error_nx    = 1'b1;
               byte_idx_nx = '0;
               state_nx    = ST_IDLE;
            end else if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = GAP_LOAD;
               state_nx = ST_GAP;
            end
         end
         ST_GAP: begin
            if (!bus_ack || !plus_mode) begin
               error_nx    = 1'b1;
               byte_idx_nx = '0;
               state_nx    = ST_IDLE;
            end else if (tmr_zero) begin
               tmr_load = 1'b1;
               if (byte_idx == LAST_IDX) begin
                  tmr_val  = CHECK_LOAD;
                  state_nx = ST_CHECK;
               end else begin
                  tmr_val     = WR_LOAD;
                  byte_idx_nx = byte_idx + 5'd1;
                  state_nx    = ST_WRITE;
               end
            end
         end
         ST_CHECK: begin
            // The arbiter may legitimately withdraw bus_ack once bus_req drops, so only plus_mode aborts here.
            byte_idx_nx = '0;
            if (!plus_mode) begin
               error_nx = 1'b1;
               state_nx = ST_IDLE;
            end else if (tmr_zero) begin
               if (mode == MODE_LOCK || asic_valid)
                  done_nx = 1'b1;
               else
                  error_nx = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               byte_idx_nx = byte_idx;
            end
         end
         default: begin
            byte_idx_nx = '0;
            state_nx    = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      on_bus  = (state == ST_WRITE) || (state == ST_GAP);
      bus_req = on_bus || (state == ST_REQ);
      io_wr   = (state == ST_WRITE);
      busy    = (state != ST_IDLE);
      io_data = on_bus ? seq_byte(mode, byte_idx) : 8'h00;
      io_addr = on_bus ? {ACID_PORT_HI, io_data} : 16'h0000;
   end

endmodule
